// File: rtl/pad_bus_arbiter.sv
// Round-robin owner of a shared bidirectional pad bus: sequences each access, drives the
// pad data/enable for writes, samples the pads for reads, and releases the bus after writes.
module pad_bus_arbiter #(
  parameter int NREQ        = 3,
  parameter int DW          = 8,
  parameter int XFER_CYCLES = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic               MasterClock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      rdata,
  output logic [DW-1:0]      pad_a,
  output logic               pad_en_n,
  input  logic [DW-1:0]      pad_i,
  output logic               busy
);

  localparam int  PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int  CMAX      = (XFER_CYCLES > TURN_CYCLES) ? XFER_CYCLES : TURN_CYCLES;
  localparam int  CW        = $clog2(CMAX + 1);
  localparam bit  HAS_TURN  = (TURN_CYCLES > 0);
  localparam int  TURN_LOAD = HAS_TURN ? (TURN_CYCLES - 1) : 0;
  localparam logic [CW-1:0]   XFER_LD  = CW'(XFER_CYCLES - 1);
  localparam logic [CW-1:0]   TURN_LD  = CW'(TURN_LOAD);
  localparam logic [NREQ-1:0] ONEHOT0  = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]   LAST_REQ = PW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic            wr_q, wr_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [DW-1:0]   pad_a_q, pad_a_d;
  logic            pad_en_n_q, pad_en_n_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic            any_req;
  logic [PW-1:0]   sel;

  // First active requester at or after the round-robin pointer, wrapping modulo NREQ.
  always_comb begin
    any_req = 1'b0;
    sel     = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        sel     = PW'(idx);
      end
    end
  end

  always_ff @(posedge MasterClock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      wr_q       <= 1'b0;
      grant_q    <= '0;
      ack_q      <= '0;
      pad_a_q    <= '0;
      pad_en_n_q <= 1'b1;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      wr_q       <= wr_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      pad_a_q    <= pad_a_d;
      pad_en_n_q <= pad_en_n_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  if (cnt_q == '0) state_d = (wr_q && HAS_TURN) ? TURN : IDLE;
      TURN:    if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    wr_d       = wr_q;
    grant_d    = grant_q;
    ack_d      = '0;
    pad_a_d    = pad_a_q;
    pad_en_n_d = pad_en_n_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = sel;
          wr_d    = we[sel];
          grant_d = ONEHOT0 << sel;
          cnt_d   = XFER_LD;
          if (we[sel]) begin
            pad_a_d    = wdata[int'(sel)*DW +: DW];
            pad_en_n_d = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          ack_d      = ONEHOT0 << owner_q;
          grant_d    = '0;
          pad_en_n_d = 1'b1;
          rr_ptr_d   = (owner_q == LAST_REQ) ? '0 : owner_q + PW'(1);
          if (!wr_q) rdata_d = pad_i;
          if (wr_q && HAS_TURN) cnt_d = TURN_LD;
        end
      end
      TURN: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
      default: begin
        grant_d    = '0;
        pad_en_n_d = 1'b1;
      end
    endcase
  end

  assign grant    = grant_q;
  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign pad_a    = pad_a_q;
  assign pad_en_n = pad_en_n_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_pad_bus_arbiter.sv
// Directed bench for pad_bus_arbiter: default instance plus an XFER_CYCLES=1/TURN_CYCLES=0 instance.
module tb_pad_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, we;
  logic [23:0] wdata;
  logic [2:0]  grant, ack;
  logic [7:0]  rdata, pad_a, pad_i;
  logic        pad_en_n, busy;

  logic [2:0]  req6, we6;
  logic [23:0] wdata6;
  logic [2:0]  grant6, ack6;
  logic [7:0]  rdata6, pad_a6, pad_i6;
  logic        pad_en_n6, busy6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pad_bus_arbiter #(.NREQ(3), .DW(8), .XFER_CYCLES(2), .TURN_CYCLES(1)) dut (
    .MasterClock(clk), .reset(rst), .req(req), .we(we), .wdata(wdata),
    .grant(grant), .ack(ack), .rdata(rdata), .pad_a(pad_a), .pad_en_n(pad_en_n),
    .pad_i(pad_i), .busy(busy)
  );

  pad_bus_arbiter #(.NREQ(3), .DW(8), .XFER_CYCLES(1), .TURN_CYCLES(0)) dut6 (
    .MasterClock(clk), .reset(rst), .req(req6), .we(we6), .wdata(wdata6),
    .grant(grant6), .ack(ack6), .rdata(rdata6), .pad_a(pad_a6), .pad_en_n(pad_en_n6),
    .pad_i(pad_i6), .busy(busy6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {grant, ack, pad_en_n, busy}
  task automatic test_reset();
    rst = 1'b1; req = '0; we = '0; wdata = '0; pad_i = '0;
    req6 = '0; we6 = '0; wdata6 = '0; pad_i6 = '0;
    tick(); tick();
    checks++;
    if ({grant, ack, pad_en_n, busy, pad_a, rdata} !== {3'b000, 3'b000, 1'b1, 1'b0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL reset_state: got g=%b a=%b en_n=%b busy=%b pad_a=%h rdata=%h", grant, ack, pad_en_n, busy, pad_a, rdata);
    end
    rst = 1'b0;
    req = 3'b010; we = 3'b010; wdata = 24'h00_77_00;
    tick();
    checks++;
    if ({grant, pad_en_n, pad_a} !== {3'b010, 1'b0, 8'h77}) begin
      errors++;
      $display("FAIL reset_prewrite: got g=%b en_n=%b pad_a=%h, want g=010 en_n=0 pad_a=77", grant, pad_en_n, pad_a);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({grant, ack, pad_en_n, busy} !== {3'b000, 3'b000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_async: got g=%b a=%b en_n=%b busy=%b, want 000 000 1 0", grant, ack, pad_en_n, busy);
    end
    req = '0; we = '0;
    #1 rst = 1'b0;
    tick(); tick();
    checks++;
    if ({busy, ack, grant} !== {1'b0, 3'b000, 3'b000}) begin
      errors++;
      $display("FAIL reset_release: got busy=%b a=%b g=%b, want 0 000 000", busy, ack, grant);
    end
  endtask

  task automatic test_single_read();
    req = 3'b001; we = 3'b000; pad_i = 8'hA5;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (c < 2) begin
        if ({grant, ack, pad_en_n, busy} !== {3'b001, 3'b000, 1'b1, 1'b1}) begin
          errors++;
          $display("FAIL read_cycle%0d: got g=%b a=%b en_n=%b busy=%b, want 001 000 1 1", c, grant, ack, pad_en_n, busy);
        end
      end else begin
        if ({grant, ack, pad_en_n, busy, rdata} !== {3'b000, 3'b001, 1'b1, 1'b0, 8'hA5}) begin
          errors++;
          $display("FAIL read_ack: got g=%b a=%b en_n=%b busy=%b rdata=%h, want 000 001 1 0 A5", grant, ack, pad_en_n, busy, rdata);
        end
      end
    end
    req = '0; pad_i = 8'h00;
    tick();
    checks++;
    if ({ack, rdata} !== {3'b000, 8'hA5}) begin
      errors++;
      $display("FAIL read_hold: got a=%b rdata=%h, want 000 A5", ack, rdata);
    end
  endtask

  task automatic test_single_write();
    req = 3'b010; we = 3'b010; wdata = 24'h00_3C_00;
    for (int c = 0; c < 2; c++) begin
      tick();
      wdata = 24'hFF_FF_FF; we = 3'b000;
      checks++;
      if ({grant, ack, pad_en_n, pad_a} !== {3'b010, 3'b000, 1'b0, 8'h3C}) begin
        errors++;
        $display("FAIL write_cycle%0d: got g=%b a=%b en_n=%b pad_a=%h, want 010 000 0 3C", c, grant, ack, pad_en_n, pad_a);
      end
    end
    tick();
    req = '0;
    checks++;
    if ({grant, ack, pad_en_n, busy} !== {3'b000, 3'b010, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL write_ack_turn: got g=%b a=%b en_n=%b busy=%b, want 000 010 1 1", grant, ack, pad_en_n, busy);
    end
    tick();
    checks++;
    if ({grant, ack, pad_en_n, busy, pad_a} !== {3'b000, 3'b000, 1'b1, 1'b0, 8'h3C}) begin
      errors++;
      $display("FAIL write_idle: got g=%b a=%b en_n=%b busy=%b pad_a=%h, want 000 000 1 0 3C", grant, ack, pad_en_n, busy, pad_a);
    end
  endtask

  task automatic test_fairness();
    logic [2:0] order [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    rst = 1'b1; #1 rst = 1'b0;
    req = 3'b111; we = 3'b000; wdata = '0;
    for (int i = 0; i < 4; i++) begin
      pad_i = 8'h10 + 8'(i);
      tick();
      checks++;
      if ({grant, ack} !== {order[i], 3'b000}) begin
        errors++;
        $display("FAIL fair_grant%0d: got g=%b a=%b, want g=%b a=000", i, grant, ack, order[i]);
      end
      tick(); tick();
      checks++;
      if ({grant, ack, rdata} !== {3'b000, order[i], 8'h10 + 8'(i)}) begin
        errors++;
        $display("FAIL fair_ack%0d: got g=%b a=%b rdata=%h, want 000 %b %h", i, grant, ack, rdata, order[i], 8'h10 + 8'(i));
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_write_read();
    logic [2:0] exp_g [7] = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b100, 3'b100, 3'b000};
    logic [2:0] exp_a [7] = '{3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b100};
    logic       exp_e [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    req = 3'b110; we = 3'b010; wdata = 24'h00_C3_00; pad_i = 8'h5A;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (c == 2) req = 3'b100;
      checks++;
      if ({grant, ack, pad_en_n} !== {exp_g[c], exp_a[c], exp_e[c]}) begin
        errors++;
        $display("FAIL wr_rd_cycle%0d: got g=%b a=%b en_n=%b, want %b %b %b", c, grant, ack, pad_en_n, exp_g[c], exp_a[c], exp_e[c]);
      end
    end
    checks++;
    if (rdata !== 8'h5A) begin
      errors++;
      $display("FAIL wr_rd_rdata: got %h want 5A", rdata);
    end
    req = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    req6 = 3'b001; we6 = 3'b001; wdata6 = 24'h00_00_11;
    for (int c = 0; c < 6; c++) begin
      logic [7:0] exp_pa;
      tick();
      exp_pa = 8'h11 * 8'(c / 2 + 1);
      if (c[0] == 1'b0) wdata6 = {16'h0, 8'h11 * 8'(c / 2 + 2)};
      checks++;
      if (c[0] == 1'b0) begin
        if ({grant6, ack6, pad_en_n6, pad_a6} !== {3'b001, 3'b000, 1'b0, exp_pa}) begin
          errors++;
          $display("FAIL b2b_cycle%0d: got g=%b a=%b en_n=%b pad_a=%h, want 001 000 0 %h", c, grant6, ack6, pad_en_n6, pad_a6, exp_pa);
        end
      end else begin
        if ({grant6, ack6, pad_en_n6} !== {3'b000, 3'b001, 1'b1}) begin
          errors++;
          $display("FAIL b2b_cycle%0d: got g=%b a=%b en_n=%b, want 000 001 1", c, grant6, ack6, pad_en_n6);
        end
      end
    end
    req6 = '0;
    tick();
    checks++;
    if ({busy6, ack6, pad_en_n6} !== {1'b0, 3'b000, 1'b1}) begin
      errors++;
      $display("FAIL b2b_idle: got busy=%b a=%b en_n=%b, want 0 000 1", busy6, ack6, pad_en_n6);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_fairness();
    test_write_read();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
